reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Sequencing controller for the reaction-timer datapath.
- Picks a pseudo-random delay in seconds and loads it into the external seconds down counter, then enables it and waits for the counter's done flag.
- After done, turns on the GO lamp and measures the player's response time in milliseconds. An early press is flagged as a fault, and no press within the limit is flagged as a timeout.
- Sits between the button debouncers, the seconds down counter and the seven-segment display driver.

Parameters:
TICKS_PER_MS, 100000, clk cycles per millisecond (100 MHz board); benches use small values
MIN_DELAY, 2, minimum random delay in seconds
MAX_DELAY, 15, maximum random delay in seconds (must be <= 31, > MIN_DELAY)
TIMEOUT_MS, 9999, response limit in ms; result saturates here
RESULT_W, 14, width of the ms result (must hold TIMEOUT_MS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begin a round (debounced)
stop  in  1  one-cycle pulse, player response (debounced)
countdone  in  1  down counter reached zero (level)
cnt_load  out  1  one-cycle load strobe to down counter
cnt_value  out  5  delay seconds presented with cnt_load
cnt_en  out  1  down counter count enable
led_go  out  1  GO lamp
busy  out  1  round in progress (LOAD/COUNT/GO)
result_ms  out  RESULT_W  measured reaction time
result_valid  out  1  one-cycle pulse, result_ms updated
early_fault  out  1  sticky: stop pressed before GO
timeout  out  1  sticky: no stop within TIMEOUT_MS
best_ms  out  RESULT_W  best score (see Optional Feature)

Behaviour:
- All state and outputs are registered. Reset acts asynchronously and forces:
  - state IDLE, LFSR 8'hA5;
  - cnt_load, cnt_en, led_go, busy, result_valid, early_fault, timeout all 0;
  - result_ms 0, cnt_value 0, prescaler 0, ms counter 0.
- LFSR is 8-bit, shift left every cycle (including IDLE), feedback q[7]^q[5]^q[4]^q[3]; never all-zero.
- Delay = MIN_DELAY + (lfsr[4:0] mod (MAX_DELAY-MIN_DELAY+1)). It is captured into cnt_value on the edge where start is accepted.
- States:
  - IDLE: outputs idle. start=1 -> LOAD.
  - LOAD (1 cycle): cnt_load=1, busy=1, early_fault/timeout cleared. Next state COUNT.
  - COUNT: cnt_en=1, busy=1.
    - stop=1 -> EARLY, with early_fault=1 and cnt_en dropping next cycle.
    - else countdone=1 -> GO, with prescaler and ms counter cleared.
    - stop has priority over countdone in the same cycle.
  - GO: led_go=1, busy=1, cnt_en=0. Counting rule per GO cycle: if prescaler==TICKS_PER_MS-1 then prescaler<=0 and ms<=ms+1, else prescaler++. Exits:
    - stop=1 -> SHOW, result_ms<=ms, result_valid=1 for exactly the first SHOW cycle.
    - else ms==TIMEOUT_MS -> TIMEOUT, result_ms<=TIMEOUT_MS, timeout=1, result_valid pulses.
    - stop wins over timeout in the same cycle.
  - SHOW / EARLY / TIMEOUT: hold result and flags, led_go=0, busy=0. start=1 -> LOAD (new round).
- Result arithmetic: with GO cycles numbered k=0.., stop sampled at cycle k gives result = floor(k/TICKS_PER_MS). Never exceeds TIMEOUT_MS; no wrap.
- Ignored inputs: start while busy; stop in IDLE/SHOW/EARLY/TIMEOUT; countdone outside COUNT.
- Reset mid-round returns to IDLE immediately, with cnt_en and led_go low.

Optional Feature:
- Macro REACTION_BEST_SCORE_EN.
- Defined:
  - best_ms resets to all-ones.
  - On each SHOW result_valid, best_ms <= min(best_ms, result_ms).
  - TIMEOUT and EARLY results never update it.
  - It survives across rounds and is cleared only by reset.
- Undefined: best_ms is tied to 0 and no comparator or register is built.

Test Plan:
- Reset then start pulse -> cnt_load high exactly one cycle. cnt_value in [2,15], equal to the formula applied to the LFSR at that edge. cnt_en=1 from the next cycle.
- TICKS_PER_MS=4: bench asserts countdone, then stop in GO cycle k=10 -> result_ms=2, result_valid one cycle, led_go falls, busy=0.
- stop during COUNT, same cycle as countdone -> EARLY, early_fault=1, led_go never rises, no result_valid.
- TICKS_PER_MS=2, TIMEOUT_MS=5, no stop -> TIMEOUT entered after GO cycle k=10, result_ms=5, timeout=1, result_valid pulses. Then a start clears timeout and pulses cnt_load.
- reset asserted mid-GO (asynchronously, between edges) -> led_go and busy go 0 immediately. Extra start pulses during COUNT produce no second cnt_load.
- With REACTION_BEST_SCORE_EN: rounds giving 7, 3, 5 -> best_ms 7, 3, 3. A following timeout leaves 3. Without the macro, best_ms stays 0.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random delay load, countdown wait, GO lamp and ms response measurement.
// Optional best-score tracking is built when REACTION_BEST_SCORE_EN is defined; otherwise best_ms is tied to 0.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS = 100000,
    parameter int MIN_DELAY    = 2,
    parameter int MAX_DELAY    = 15,
    parameter int TIMEOUT_MS   = 9999,
    parameter int RESULT_W     = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                countdone,
    output logic                cnt_load,
    output logic [4:0]          cnt_value,
    output logic                cnt_en,
    output logic                led_go,
    output logic                busy,
    output logic [RESULT_W-1:0] result_ms,
    output logic                result_valid,
    output logic                early_fault,
    output logic                timeout,
    output logic [RESULT_W-1:0] best_ms
);

    localparam int DELAY_RANGE = MAX_DELAY - MIN_DELAY + 1;
    localparam int PRE_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [RESULT_W-1:0] MS_LIMIT = RESULT_W'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_GO,
        S_SHOW,
        S_EARLY,
        S_TIMEOUT
    } state_t;

    state_t              state_reg;
    logic [7:0]          lfsr_reg;
    logic [7:0]          lfsr_next;
    logic [4:0]          delay_calc;
    logic [PRE_W-1:0]    prescaler_reg;
    logic [RESULT_W-1:0] ms_reg;

    // Free-running LFSR: the delay depends on how long the player waited before pressing start.
    assign lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign delay_calc = 5'(MIN_DELAY + (int'(lfsr_reg[4:0]) % DELAY_RANGE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            lfsr_reg      <= 8'hA5;
            cnt_load      <= 1'b0;
            cnt_value     <= '0;
            cnt_en        <= 1'b0;
            led_go        <= 1'b0;
            busy          <= 1'b0;
            result_ms     <= '0;
            result_valid  <= 1'b0;
            early_fault   <= 1'b0;
            timeout       <= 1'b0;
            prescaler_reg <= '0;
            ms_reg        <= '0;
        end else begin
            lfsr_reg     <= lfsr_next;
            cnt_load     <= 1'b0;
            result_valid <= 1'b0;
            case (state_reg)
                S_IDLE, S_SHOW, S_EARLY, S_TIMEOUT: begin
                    if (start) begin
                        state_reg   <= S_LOAD;
                        cnt_load    <= 1'b1;
                        cnt_value   <= delay_calc;
                        busy        <= 1'b1;
                        early_fault <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state_reg <= S_COUNT;
                    cnt_en    <= 1'b1;
                end
                S_COUNT: begin
                    // An early press beats a simultaneous countdone.
                    if (stop) begin
                        state_reg   <= S_EARLY;
                        early_fault <= 1'b1;
                        cnt_en      <= 1'b0;
                        busy        <= 1'b0;
                    end else if (countdone) begin
                        state_reg     <= S_GO;
                        cnt_en        <= 1'b0;
                        led_go        <= 1'b1;
                        prescaler_reg <= '0;
                        ms_reg        <= '0;
                    end
                end
                S_GO: begin
                    if (stop) begin
                        state_reg    <= S_SHOW;
                        result_ms    <= ms_reg;
                        result_valid <= 1'b1;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                    end else if (ms_reg == MS_LIMIT) begin
                        state_reg    <= S_TIMEOUT;
                        result_ms    <= MS_LIMIT;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                    end else if (prescaler_reg == PRE_LAST) begin
                        prescaler_reg <= '0;
                        ms_reg        <= ms_reg + 1'b1;
                    end else begin
                        prescaler_reg <= prescaler_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    cnt_en    <= 1'b0;
                    led_go    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_SCORE_EN
    logic [RESULT_W-1:0] best_reg;

    // Only genuine responses (SHOW) compete; timeouts and early presses never count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_reg <= '1;
        end else if (result_valid && (state_reg == S_SHOW) && (result_ms < best_reg)) begin
            best_reg <= result_ms;
        end
    end

    assign best_ms = best_reg;
`else
    assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: directed rounds push expected results, a monitor checks each result_valid.
module tb_reaction_timer_ctrl;

    localparam int TICKS    = 4;
    localparam int MIN_D    = 2;
    localparam int MAX_D    = 15;
    localparam int TMO_MS   = 9;
    localparam int RW       = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          countdone = 1'b0;
    logic          cnt_load;
    logic [4:0]    cnt_value;
    logic          cnt_en;
    logic          led_go;
    logic          busy;
    logic [RW-1:0] result_ms;
    logic          result_valid;
    logic          early_fault;
    logic          timeout;
    logic [RW-1:0] best_ms;

    int tests = 0;
    int errors = 0;

    typedef struct {
        int res;
        bit tmo;
        bit early;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]    lfsr_model;
    logic [RW-1:0] exp_best;

    reaction_timer_ctrl #(
        .TICKS_PER_MS(TICKS),
        .MIN_DELAY(MIN_D),
        .MAX_DELAY(MAX_D),
        .TIMEOUT_MS(TMO_MS),
        .RESULT_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .countdone(countdone),
        .cnt_load(cnt_load),
        .cnt_value(cnt_value),
        .cnt_en(cnt_en),
        .led_go(led_go),
        .busy(busy),
        .result_ms(result_ms),
        .result_valid(result_valid),
        .early_fault(early_fault),
        .timeout(timeout),
        .best_ms(best_ms)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_model <= 8'hA5;
        else lfsr_model <= {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result_valid: result_ms=%0d with nothing expected", result_ms);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result_ms !== RW'(e.res) || timeout !== e.tmo || early_fault !== e.early) begin
                    errors++;
                    $display("FAIL result: got ms=%0d tmo=%0b early=%0b expected ms=%0d tmo=%0b early=%0b",
                             result_ms, timeout, early_fault, e.res, e.tmo, e.early);
                end else begin
                    $display("ok   result: ms=%0d tmo=%0b", result_ms, timeout);
                end
            end
        end
    end

    task automatic start_round();
        logic [4:0] exp_val;
        logic [4:0] low5;
        low5    = lfsr_model[4:0];
        exp_val = 5'(MIN_D + (int'(low5) % (MAX_D - MIN_D + 1)));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_strobe", cnt_load, 1);
        check("load_value", cnt_value, exp_val);
        check("load_busy", busy, 1);
        check("load_flags", {early_fault, timeout}, 0);
        tick();
        check("count_load_low", cnt_load, 0);
        check("count_en", cnt_en, 1);
        repeat (3) tick();
    endtask

    task automatic enter_go();
        countdone = 1'b1;
        tick();
        countdone = 1'b0;
        check("go_lamp", {led_go, cnt_en, busy}, 3'b101);
    endtask

    task automatic stop_at(input int k);
        exp_t e;
        repeat (k) tick();
        e.res = k / TICKS;
        e.tmo = 1'b0;
        e.early = 1'b0;
        exp_q.push_back(e);
`ifdef REACTION_BEST_SCORE_EN
        if (RW'(e.res) < exp_best) exp_best = RW'(e.res);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("show_lamp_busy", {led_go, busy}, 0);
        check("show_valid", result_valid, 1);
        tick();
        check("show_valid_one_cycle", result_valid, 0);
        check("best_ms", best_ms, exp_best);
    endtask

    initial begin
        exp_t e;
        int n;
`ifdef REACTION_BEST_SCORE_EN
        exp_best = '1;
`else
        exp_best = '0;
`endif
        #12;
        check("reset_outputs", {cnt_load, cnt_en, led_go, busy, result_valid, early_fault, timeout}, 0);
        check("reset_result", result_ms, 0);
        check("reset_cnt_value", cnt_value, 0);
        check("reset_best", best_ms, exp_best);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Best-score sequence: 7, 3, 5.
        start_round(); enter_go(); stop_at(28);
        start_round(); enter_go(); stop_at(12);
        start_round(); enter_go(); stop_at(20);

        // Timeout: ms reaches 9 in GO cycle 36.
        start_round(); enter_go();
        e.res = TMO_MS; e.tmo = 1'b1; e.early = 1'b0;
        exp_q.push_back(e);
        n = 0;
        while (!timeout && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 37);
        check("timeout_lamp_busy", {led_go, busy}, 0);
        tick();
        check("best_after_timeout", best_ms, exp_best);

        // New round from TIMEOUT clears the flag; k=10 at 4 ticks/ms gives 2.
        start_round(); enter_go(); stop_at(10);

        // Early press coinciding with countdone.
        start_round();
        stop = 1'b1;
        countdone = 1'b1;
        tick();
        stop = 1'b0;
        countdone = 1'b0;
        check("early_state", {early_fault, cnt_en, busy, led_go}, 4'b1000);
        n = 0;
        repeat (5) begin
            tick();
            if (led_go || result_valid) n++;
        end
        check("early_no_go", n, 0);
        check("best_after_early", best_ms, exp_best);

        // Extra start during COUNT, then asynchronous reset mid-GO.
        start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("no_reload_in_count", {cnt_load, cnt_en}, 2'b01);
        enter_go();
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {led_go, busy, cnt_en}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef REACTION_BEST_SCORE_EN
        exp_best = '1;
`endif
        tick();
        check("post_reset_result", result_ms, 0);
        check("post_reset_best", best_ms, exp_best);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
